// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline stages.
// Contents:
//   XLEN, INSTR_BYTES  - datapath width and instruction size in bytes
//   DEFAULT_RESET_PC   - PC loaded at reset unless a stage overrides it
//   ifid_t             - IF/ID payload {instr[63:32], pcplus4[31:0]}; decode
//                        slices the same struct, so both ends always agree
//   pc_inc()           - next sequential PC (wraps modulo 2^32)
package arm_pipe_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pcplus4;
   } ifid_t;

   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// Signals:
//   imem_req_valid / imem_req_ready - request handshake
//   imem_req_addr                   - fetch address
//   imem_rsp_valid / imem_rsp_data  - in-order response, no backpressure
// Modports:
//   master - the fetch stage (issues requests, consumes responses)
//   slave  - the instruction memory
interface fetch_stage_if;
   import arm_pipe_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding IF/ID payloads between the imem and decode.
// Ports:
//   clk, reset      - clock; synchronous active-low reset (zeroes storage)
//   push, push_data - write one entry
//   pop             - retire the head entry (caller never pops when empty)
//   flush           - discard all entries; wins over push and pop
//   head            - head entry, straight from the storage registers
//   count           - number of valid entries (0..DEPTH)
// Push and pop in the same cycle are legal at any fill level, including
// full: the write lands in the slot the pop is freeing.
module fetch_fifo
   import arm_pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  ifid_t         push_data,
   input  logic          pop,
   input  logic          flush,
   output ifid_t         head,
   output logic [CW-1:0] count
);

   ifid_t         mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg          <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues in-order fetches to a variable-latency
// instruction memory, buffers responses in a prefetch FIFO and presents
// {instr, pc+4} to decode.
// Ports:
//   clk, reset        - clock; synchronous active-low reset
//   imem              - instruction-memory bus (master side)
//   redirect_valid/pc - PC write from writeback; highest priority
//   stall_d           - decode cannot accept, hold the outputs
//   valid_d, instr_d, pcplus4_d - IF/ID payload, registered
// Credit scheme: buffered (count) + outstanding (out) + responses still to
// be discarded after a redirect (drop) never exceeds DEPTH, so a response
// always has a FIFO slot waiting for it.
module fetch_stage
   import arm_pipe_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   fetch_stage_if.master     imem,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              stall_d,
   output logic              valid_d,
   output logic [XLEN-1:0]   instr_d,
   output logic [XLEN-1:0]   pcplus4_d
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] rsp_pc_reg;   // address of the next response to be kept
   logic [CW-1:0]   out_reg;
   logic [CW-1:0]   drop_reg;
   logic [CW-1:0]   count;
   logic [CW:0]     in_use;
   logic            accept;
   logic            rsp_drop;
   logic            rsp_push;
   logic            rsp_owned;
   logic            fifo_push;
   logic            fifo_pop;
   ifid_t           push_data;
   ifid_t           head;

   assign in_use = {1'b0, count} + {1'b0, out_reg} + {1'b0, drop_reg};

   // Gated by reset so nothing is requested while the stage is held.
   assign imem.imem_req_valid = reset && !redirect_valid && (in_use < (CW+1)'(DEPTH));
   assign imem.imem_req_addr  = pc_reg;
   assign accept              = imem.imem_req_valid && imem.imem_req_ready;

   // A response with nothing outstanding and nothing to drop belongs to a
   // request abandoned by reset and is ignored.
   assign rsp_drop  = imem.imem_rsp_valid && (drop_reg != '0);
   assign rsp_push  = imem.imem_rsp_valid && (drop_reg == '0) && (out_reg != '0);
   assign rsp_owned = rsp_drop || rsp_push;

   assign fifo_push = rsp_push && !redirect_valid;
   assign fifo_pop  = valid_d && !stall_d && !redirect_valid;
   assign push_data = '{instr: imem.imem_rsp_data, pcplus4: pc_inc(rsp_pc_reg)};

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg     <= RESET_PC;
         rsp_pc_reg <= RESET_PC;
         out_reg    <= '0;
         drop_reg   <= '0;
      end else if (redirect_valid) begin
         pc_reg     <= redirect_pc;
         rsp_pc_reg <= redirect_pc;
         out_reg    <= '0;
         // Everything still in flight becomes a drop credit, less the
         // response (if any) being discarded right now.
         drop_reg   <= drop_reg + out_reg - CW'(rsp_owned);
      end else begin
         if (accept) begin
            pc_reg <= pc_inc(pc_reg);
         end
         // Dropped responses do not advance rsp_pc: it was reloaded with the
         // redirect target, which is the first address that will be kept.
         if (rsp_push) begin
            rsp_pc_reg <= pc_inc(rsp_pc_reg);
         end
         out_reg <= out_reg + CW'(accept) - CW'(rsp_push);
         if (rsp_drop) begin
            drop_reg <= drop_reg - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (count)
   );

   assign valid_d   = (count != '0);
   assign instr_d   = head.instr;
   assign pcplus4_d = head.pcplus4;

endmodule
